// File: rtl/wu_decode_pkg.sv
// Shared encodings for the WU decode stage.
// Contents:
//   word_type_e - WU word type carried in data[31:30]
//   wud_state_e - decoder FSM states
//   field bit positions for HEADER and OPTION words
//   rec_width() - packed record width for a given option count
package wu_decode_pkg;

  typedef enum logic [1:0] {
    WtNop    = 2'b00,
    WtHeader = 2'b01,
    WtOption = 2'b10,
    WtEnd    = 2'b11
  } word_type_e;

  typedef enum logic [1:0] {
    WudIdle    = 2'b00,
    WudOpts    = 2'b01,
    WudWaitEnd = 2'b10,
    WudErr     = 2'b11
  } wud_state_e;

  // Word type field (all words)
  localparam int unsigned TypeHi    = 31;
  localparam int unsigned TypeLo    = 30;
  // HEADER fields
  localparam int unsigned OpcodeHi  = 29;
  localparam int unsigned OpcodeLo  = 26;
  localparam int unsigned NumOptsHi = 25;
  localparam int unsigned NumOptsLo = 22;
  localparam int unsigned TagHi     = 21;
  localparam int unsigned TagLo     = 0;
  // OPTION fields
  localparam int unsigned OptIdHi   = 29;
  localparam int unsigned OptIdLo   = 26;
  localparam int unsigned OptValHi  = 15;
  localparam int unsigned OptValLo  = 0;

  localparam int unsigned OpcodeW   = 4;
  localparam int unsigned TagW      = 22;
  localparam int unsigned NumOptsW  = 4;
  localparam int unsigned OptIdW    = 4;
  localparam int unsigned OptValW   = 16;

  // Record layout, MSB first: opcode, tag, num_opts, opt_id[], opt_val[]
  function automatic int unsigned rec_width(input int unsigned max_opts);
    return OpcodeW + TagW + NumOptsW + max_opts * (OptIdW + OptValW);
  endfunction

endpackage

// File: rtl/wud_fifo.sv
// Generic first-word-fall-through FIFO with occupancy count.
// Ports:
//   clk, rst_n       - clock, asynchronous active-low reset
//   push, wdata      - write request and data (ignored when full unless popping)
//   pop              - read request (ignored when empty)
//   rdata            - head entry, valid whenever count != 0
//   count            - current occupancy
//   count_next       - occupancy after this cycle's push/pop
//   full             - count == Depth
module wud_fifo #(
  parameter int unsigned Width = 8,
  parameter int unsigned Depth = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [Width-1:0]         wdata,
  input  logic                     pop,
  output logic [Width-1:0]         rdata,
  output logic [$clog2(Depth):0]   count,
  output logic [$clog2(Depth):0]   count_next,
  output logic                     full
);

  localparam int unsigned PtrW = $clog2(Depth);
  localparam int unsigned CntW = PtrW + 1;

  logic [Width-1:0] mem_q [Depth];
  logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]  count_q;
  logic             push_ok, pop_ok;

  assign full    = (count_q == CntW'(Depth));
  assign pop_ok  = pop && (count_q != '0);
  // A pop frees the slot this cycle, so a push into a full FIFO is accepted alongside it.
  assign push_ok = push && (!full || pop_ok);

  assign count      = count_q;
  assign count_next = count_q + CntW'(push_ok) - CntW'(pop_ok);
  assign rdata      = mem_q[rd_ptr_q];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_next;
    end
  end

  // Storage needs no reset: entries are only observed once written.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= wdata;
  end

endmodule

// File: rtl/wu_decode.sv
// WU decode stage: parses the WU memory word stream into instruction records,
// queues them in a FWFT FIFO and hands them to the manager control consumer.
// Optional build macro: WUD_PARITY_CHECK_EN adds input wum__wud__parity (even
// parity over the word); a mismatching valid word forces the error state.
// Ports:
//   clk, reset_poweron_n          - clock, asynchronous active-low reset
//   wum__wud__valid/data          - word stream from WU memory
//   wum__wud__parity              - (WUD_PARITY_CHECK_EN only) even parity bit
//   wud__wuf__stall               - registered stall to the fetch stage
//   wud__mcntl__valid/ready       - record handshake
//   wud__mcntl__opcode/tag/...    - head record fields, zero when no record
//   wud__mcntl__err               - sticky decode/overflow error
module wu_decode
  import wu_decode_pkg::*;
#(
  parameter int unsigned WU_WORD_W    = 32,
  parameter int unsigned MAX_OPTS     = 4,
  parameter int unsigned FIFO_DEPTH   = 8,
  parameter int unsigned STALL_MARGIN = 4
) (
  input  logic                    clk,
  input  logic                    reset_poweron_n,
  input  logic                    wum__wud__valid,
  input  logic [WU_WORD_W-1:0]    wum__wud__data,
`ifdef WUD_PARITY_CHECK_EN
  input  logic                    wum__wud__parity,
`endif
  output logic                    wud__wuf__stall,
  output logic                    wud__mcntl__valid,
  input  logic                    mcntl__wud__ready,
  output logic [3:0]              wud__mcntl__opcode,
  output logic [21:0]             wud__mcntl__tag,
  output logic [3:0]              wud__mcntl__num_opts,
  output logic [4*MAX_OPTS-1:0]   wud__mcntl__opt_id,
  output logic [16*MAX_OPTS-1:0]  wud__mcntl__opt_val,
  output logic                    wud__mcntl__err
);

  localparam int unsigned RecW        = rec_width(MAX_OPTS);
  localparam int unsigned CntW        = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CntW-1:0] StallThresh = CntW'(FIFO_DEPTH - STALL_MARGIN);
  localparam logic [3:0]      MaxOptsN    = 4'(MAX_OPTS);

  // Word field extraction
  word_type_e           wtype;
  logic [OpcodeW-1:0]   w_opcode;
  logic [NumOptsW-1:0]  w_nopts;
  logic [TagW-1:0]      w_tag;
  logic [OptIdW-1:0]    w_id;
  logic [OptValW-1:0]   w_val;

  assign wtype    = word_type_e'(wum__wud__data[TypeHi:TypeLo]);
  assign w_opcode = wum__wud__data[OpcodeHi:OpcodeLo];
  assign w_nopts  = wum__wud__data[NumOptsHi:NumOptsLo];
  assign w_tag    = wum__wud__data[TagHi:TagLo];
  assign w_id     = wum__wud__data[OptIdHi:OptIdLo];
  assign w_val    = wum__wud__data[OptValHi:OptValLo];

  if (WU_WORD_W > 32) begin : g_wide_word
    logic unused_hi_bits;
    assign unused_hi_bits = ^wum__wud__data[WU_WORD_W-1:32];
  end

  logic parity_err;
`ifdef WUD_PARITY_CHECK_EN
  assign parity_err = (^wum__wud__data) != wum__wud__parity;
`else
  assign parity_err = 1'b0;
`endif

  // Decoder state and record under assembly
  wud_state_e           state_q;
  logic [OpcodeW-1:0]   opcode_q;
  logic [TagW-1:0]      tag_q;
  logic [NumOptsW-1:0]  num_opts_q;
  logic [3:0]           opt_cnt_q;
  logic [OptIdW-1:0]    opt_id_q  [MAX_OPTS];
  logic [OptValW-1:0]   opt_val_q [MAX_OPTS];
  logic                 err_q;
  logic                 stall_q;

  // FIFO interface
  logic [RecW-1:0]      fifo_wdata, fifo_rdata;
  logic [CntW-1:0]      fifo_count, fifo_count_next;
  logic                 fifo_full;
  logic                 out_valid, pop, push_req, overflow;
  logic                 active, word_ok, proto_err, err_event;

  assign out_valid = (fifo_count != '0);
  assign pop       = out_valid && mcntl__wud__ready;

  assign active    = wum__wud__valid && (state_q != WudErr);
  assign word_ok   = active && !parity_err;
  assign push_req  = word_ok && (state_q == WudWaitEnd) && (wtype == WtEnd);
  assign overflow  = push_req && fifo_full && !pop;

  // Word types that are illegal in the current state; NOPs are always legal.
  always_comb begin
    proto_err = 1'b0;
    unique case (state_q)
      WudIdle:    proto_err = (wtype == WtOption) || (wtype == WtEnd) ||
                              ((wtype == WtHeader) && (w_nopts > MaxOptsN));
      WudOpts:    proto_err = (wtype == WtHeader) || (wtype == WtEnd);
      WudWaitEnd: proto_err = (wtype == WtHeader) || (wtype == WtOption);
      WudErr:     proto_err = 1'b0;
    endcase
  end

  assign err_event = active && (parity_err || proto_err || overflow);

  always_ff @(posedge clk or negedge reset_poweron_n) begin
    if (!reset_poweron_n) begin
      state_q    <= WudIdle;
      opcode_q   <= '0;
      tag_q      <= '0;
      num_opts_q <= '0;
      opt_cnt_q  <= '0;
      err_q      <= 1'b0;
      stall_q    <= 1'b0;
      for (int i = 0; i < int'(MAX_OPTS); i++) begin
        opt_id_q[i]  <= '0;
        opt_val_q[i] <= '0;
      end
    end else begin
      stall_q <= (fifo_count_next >= StallThresh);
      if (err_event) begin
        state_q <= WudErr;
        err_q   <= 1'b1;
      end else if (word_ok) begin
        unique case (state_q)
          WudIdle: begin
            if (wtype == WtHeader) begin
              opcode_q   <= w_opcode;
              tag_q      <= w_tag;
              num_opts_q <= w_nopts;
              opt_cnt_q  <= '0;
              for (int i = 0; i < int'(MAX_OPTS); i++) begin
                opt_id_q[i]  <= '0;
                opt_val_q[i] <= '0;
              end
              state_q <= (w_nopts == '0) ? WudWaitEnd : WudOpts;
            end
          end
          WudOpts: begin
            if (wtype == WtOption) begin
              for (int i = 0; i < int'(MAX_OPTS); i++) begin
                if (opt_cnt_q == 4'(i)) begin
                  opt_id_q[i]  <= w_id;
                  opt_val_q[i] <= w_val;
                end
              end
              opt_cnt_q <= opt_cnt_q + 4'd1;
              if (opt_cnt_q == num_opts_q - 4'd1) state_q <= WudWaitEnd;
            end
          end
          WudWaitEnd: begin
            // The record itself is pushed by push_req on this same edge.
            if (wtype == WtEnd) state_q <= WudIdle;
          end
          WudErr: ;
        endcase
      end
    end
  end

  // Pack the record: opcode, tag, num_opts, opt_id slots, opt_val slots (slot 0 in LSBs).
  logic [4*MAX_OPTS-1:0]  id_flat;
  logic [16*MAX_OPTS-1:0] val_flat;

  always_comb begin
    id_flat  = '0;
    val_flat = '0;
    for (int i = 0; i < int'(MAX_OPTS); i++) begin
      id_flat[i*4 +: 4]   = opt_id_q[i];
      val_flat[i*16 +: 16] = opt_val_q[i];
    end
  end

  assign fifo_wdata = {opcode_q, tag_q, num_opts_q, id_flat, val_flat};

  wud_fifo #(
    .Width (RecW),
    .Depth (FIFO_DEPTH)
  ) u_fifo (
    .clk        (clk),
    .rst_n      (reset_poweron_n),
    .push       (push_req),
    .wdata      (fifo_wdata),
    .pop        (pop),
    .rdata      (fifo_rdata),
    .count      (fifo_count),
    .count_next (fifo_count_next),
    .full       (fifo_full)
  );

  // Record fields are masked to zero while empty so stale storage never shows.
  assign wud__mcntl__valid    = out_valid;
  assign wud__mcntl__opcode   = out_valid ? fifo_rdata[RecW-1 -: 4]  : '0;
  assign wud__mcntl__tag      = out_valid ? fifo_rdata[RecW-5 -: 22] : '0;
  assign wud__mcntl__num_opts = out_valid ? fifo_rdata[RecW-27 -: 4] : '0;
  assign wud__mcntl__opt_id   = out_valid ? fifo_rdata[20*MAX_OPTS-1 -: 4*MAX_OPTS] : '0;
  assign wud__mcntl__opt_val  = out_valid ? fifo_rdata[16*MAX_OPTS-1:0] : '0;
  assign wud__mcntl__err      = err_q;
  assign wud__wuf__stall      = stall_q;

endmodule

// File: tb/tb_wu_decode.sv
// Directed bench for wu_decode (default parameters: 32-bit words, 4 options,
// 8-entry FIFO, stall margin 4). Inputs change 1 time unit after posedge and
// outputs are sampled there as well.
module tb_wu_decode;

  logic        clk = 1'b0;
  logic        reset_poweron_n = 1'b0;
  logic        wum__wud__valid = 1'b0;
  logic [31:0] wum__wud__data = '0;
  logic        mcntl__wud__ready = 1'b0;
  logic        wud__wuf__stall;
  logic        wud__mcntl__valid;
  logic [3:0]  wud__mcntl__opcode;
  logic [21:0] wud__mcntl__tag;
  logic [3:0]  wud__mcntl__num_opts;
  logic [15:0] wud__mcntl__opt_id;
  logic [63:0] wud__mcntl__opt_val;
  logic        wud__mcntl__err;

  int checks = 0;
  int failures = 0;

`ifdef WUD_PARITY_CHECK_EN
  logic par_flip = 1'b0;
  logic wum__wud__parity;
  assign wum__wud__parity = (^wum__wud__data) ^ par_flip;
`endif

  localparam logic [31:0] EndW = 32'hC000_0000;
  localparam logic [31:0] NopW = 32'h0000_0000;

  always #5 clk = ~clk;

  wu_decode dut (
    .clk                  (clk),
    .reset_poweron_n      (reset_poweron_n),
    .wum__wud__valid      (wum__wud__valid),
    .wum__wud__data       (wum__wud__data),
`ifdef WUD_PARITY_CHECK_EN
    .wum__wud__parity     (wum__wud__parity),
`endif
    .wud__wuf__stall      (wud__wuf__stall),
    .wud__mcntl__valid    (wud__mcntl__valid),
    .mcntl__wud__ready    (mcntl__wud__ready),
    .wud__mcntl__opcode   (wud__mcntl__opcode),
    .wud__mcntl__tag      (wud__mcntl__tag),
    .wud__mcntl__num_opts (wud__mcntl__num_opts),
    .wud__mcntl__opt_id   (wud__mcntl__opt_id),
    .wud__mcntl__opt_val  (wud__mcntl__opt_val),
    .wud__mcntl__err      (wud__mcntl__err)
  );

  function automatic logic [31:0] hdr(input logic [3:0] op, input logic [3:0] n,
                                      input logic [21:0] tag);
    return {2'b01, op, n, tag};
  endfunction

  function automatic logic [31:0] opt(input logic [3:0] id, input logic [15:0] val);
    return {2'b10, id, 10'd0, val};
  endfunction

  task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", name, obs, exp);
    end
  endtask

  task automatic send(input logic [31:0] w);
    wum__wud__valid = 1'b1;
    wum__wud__data  = w;
    @(posedge clk);
    #1;
    wum__wud__valid = 1'b0;
    wum__wud__data  = '0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset_poweron_n = 1'b0;
    #3;
    reset_poweron_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    step();
    // Reset state
    chk("rst_valid", 64'(wud__mcntl__valid), 64'd0);
    chk("rst_stall", 64'(wud__wuf__stall), 64'd0);
    chk("rst_err", 64'(wud__mcntl__err), 64'd0);
    chk("rst_opcode", 64'(wud__mcntl__opcode), 64'd0);
    chk("rst_opt_val", wud__mcntl__opt_val, 64'd0);
    reset_poweron_n = 1'b1;

    // 1. Basic record, consumer ready
    mcntl__wud__ready = 1'b1;
    send(hdr(4'd3, 4'd2, 22'h1234));
    send(opt(4'd1, 16'hAAAA));
    send(opt(4'd7, 16'h0055));
    chk("t1_before_end", 64'(wud__mcntl__valid), 64'd0);
    send(EndW);
    chk("t1_valid", 64'(wud__mcntl__valid), 64'd1);
    chk("t1_opcode", 64'(wud__mcntl__opcode), 64'd3);
    chk("t1_tag", 64'(wud__mcntl__tag), 64'h1234);
    chk("t1_num_opts", 64'(wud__mcntl__num_opts), 64'd2);
    chk("t1_opt_id", 64'(wud__mcntl__opt_id), 64'h0071);
    chk("t1_opt_val", wud__mcntl__opt_val, 64'h0000_0000_0055_AAAA);
    chk("t1_err", 64'(wud__mcntl__err), 64'd0);
    step();
    chk("t1_popped", 64'(wud__mcntl__valid), 64'd0);

    // 2. Zero options with NOPs; option slots must be cleared
    mcntl__wud__ready = 1'b0;
    send(hdr(4'd5, 4'd0, 22'h3FFFFF));
    send(NopW);
    send(NopW);
    send(EndW);
    chk("t2_valid", 64'(wud__mcntl__valid), 64'd1);
    chk("t2_opcode", 64'(wud__mcntl__opcode), 64'd5);
    chk("t2_tag", 64'(wud__mcntl__tag), 64'h3FFFFF);
    chk("t2_num_opts", 64'(wud__mcntl__num_opts), 64'd0);
    chk("t2_opt_id", 64'(wud__mcntl__opt_id), 64'd0);
    chk("t2_opt_val", wud__mcntl__opt_val, 64'd0);
    mcntl__wud__ready = 1'b1;
    step();
    mcntl__wud__ready = 1'b0;
    chk("t2_popped", 64'(wud__mcntl__valid), 64'd0);

    // Maximum option count fills every slot
    send(hdr(4'd2, 4'd4, 22'h2AAAAA));
    send(opt(4'd1, 16'h1111));
    send(opt(4'd2, 16'h2222));
    send(opt(4'd3, 16'h3333));
    send(opt(4'd15, 16'hFFFF));
    send(EndW);
    chk("tmax_num_opts", 64'(wud__mcntl__num_opts), 64'd4);
    chk("tmax_opt_id", 64'(wud__mcntl__opt_id), 64'hF321);
    chk("tmax_opt_val", wud__mcntl__opt_val, 64'hFFFF_3333_2222_1111);
    chk("tmax_err", 64'(wud__mcntl__err), 64'd0);
    mcntl__wud__ready = 1'b1;
    step();
    mcntl__wud__ready = 1'b0;

    // 3. Stall threshold and overflow, ready held low
    for (int i = 1; i <= 8; i++) begin
      send(hdr(4'(i), 4'd0, 22'(i)));
      send(EndW);
      if (i == 3) chk("t3_stall_at3", 64'(wud__wuf__stall), 64'd0);
      if (i == 4) chk("t3_stall_at4", 64'(wud__wuf__stall), 64'd1);
    end
    chk("t3_err_full", 64'(wud__mcntl__err), 64'd0);
    send(hdr(4'd9, 4'd0, 22'd9));
    send(EndW);
    chk("t3_overflow_err", 64'(wud__mcntl__err), 64'd1);
    // Words in the error state are dropped; queue still drains in order
    send(hdr(4'd10, 4'd0, 22'd10));
    send(EndW);
    mcntl__wud__ready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      chk("t3_drain_valid", 64'(wud__mcntl__valid), 64'd1);
      chk("t3_drain_opcode", 64'(wud__mcntl__opcode), 64'(i));
      if (i == 5) chk("t3_stall_cnt4", 64'(wud__wuf__stall), 64'd1);
      if (i == 6) chk("t3_stall_cnt3", 64'(wud__wuf__stall), 64'd0);
      step();
    end
    chk("t3_drained", 64'(wud__mcntl__valid), 64'd0);
    chk("t3_err_sticky", 64'(wud__mcntl__err), 64'd1);
    mcntl__wud__ready = 1'b0;
    do_reset();
    chk("t3_err_cleared", 64'(wud__mcntl__err), 64'd0);

    // 4a. OPTION in IDLE
    send(opt(4'd1, 16'h0001));
    chk("t4a_err", 64'(wud__mcntl__err), 64'd1);
    send(hdr(4'd1, 4'd0, 22'd1));
    send(EndW);
    chk("t4a_no_record", 64'(wud__mcntl__valid), 64'd0);
    do_reset();
    // 4b. HEADER with too many options
    send(hdr(4'd1, 4'd9, 22'd5));
    chk("t4b_err", 64'(wud__mcntl__err), 64'd1);
    send(EndW);
    chk("t4b_no_record", 64'(wud__mcntl__valid), 64'd0);
    do_reset();

    // 5. Push and pop on the same edge while full
    for (int i = 1; i <= 8; i++) begin
      send(hdr(4'(i), 4'd0, 22'(12'h100 + i)));
      send(EndW);
    end
    chk("t5_stall_full", 64'(wud__wuf__stall), 64'd1);
    send(hdr(4'd9, 4'd0, 22'h109));
    mcntl__wud__ready = 1'b1;
    send(EndW);
    mcntl__wud__ready = 1'b0;
    chk("t5_no_err", 64'(wud__mcntl__err), 64'd0);
    mcntl__wud__ready = 1'b1;
    for (int i = 2; i <= 9; i++) begin
      chk("t5_drain_opcode", 64'(wud__mcntl__opcode), 64'(i));
      chk("t5_drain_tag", 64'(wud__mcntl__tag), 64'(12'h100 + i));
      step();
    end
    chk("t5_drained", 64'(wud__mcntl__valid), 64'd0);
    mcntl__wud__ready = 1'b0;

    // 6. Asynchronous reset mid-instruction
    send(hdr(4'd4, 4'd0, 22'h55));
    send(EndW);
    chk("t6_queued", 64'(wud__mcntl__valid), 64'd1);
    send(hdr(4'd6, 4'd2, 22'h77));
    send(opt(4'd3, 16'hBEEF));
    #2;
    reset_poweron_n = 1'b0;
    #1;
    chk("t6_rst_valid", 64'(wud__mcntl__valid), 64'd0);
    chk("t6_rst_opcode", 64'(wud__mcntl__opcode), 64'd0);
    chk("t6_rst_tag", 64'(wud__mcntl__tag), 64'd0);
    #1;
    reset_poweron_n = 1'b1;
    send(hdr(4'd8, 4'd1, 22'h3));
    send(opt(4'd2, 16'h1234));
    send(EndW);
    chk("t6_valid", 64'(wud__mcntl__valid), 64'd1);
    chk("t6_opcode", 64'(wud__mcntl__opcode), 64'd8);
    chk("t6_num_opts", 64'(wud__mcntl__num_opts), 64'd1);
    chk("t6_opt_id", 64'(wud__mcntl__opt_id), 64'h0002);
    chk("t6_opt_val", wud__mcntl__opt_val, 64'h1234);
    chk("t6_err", 64'(wud__mcntl__err), 64'd0);

`ifdef WUD_PARITY_CHECK_EN
    do_reset();
    par_flip = 1'b1;
    send(NopW);
    par_flip = 1'b0;
    chk("par_err", 64'(wud__mcntl__err), 64'd1);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/wu_decode.md
Name: wu_decode

Overview:
- Downstream neighbour of the WU fetch stage. Consumes the word stream returned by WU memory for each fetch read and parses it into complete work-unit instruction records.
- Buffers the records in a small FIFO and presents them to the manager control consumer over a valid/ready handshake.
- Drives the stall input of the fetch stage so that in-flight reads never overflow the FIFO.

Parameters:
- WU_WORD_W, 32, width of one WU memory word.
- MAX_OPTS, 4, maximum option words per instruction (1..15).
- FIFO_DEPTH, 8, decoded-record FIFO entries (power of 2, >=4).
- STALL_MARGIN, 4, free-entry reserve covering fetch registered-stall plus memory read latency.

Ports:
- clk  in  1  clock, all logic on posedge.
- reset_poweron_n  in  1  asynchronous, active-low reset.
- wum__wud__valid  in  1  read data valid, one cycle per word.
- wum__wud__data  in  WU_WORD_W  WU word.
- wud__wuf__stall  out  1  stall request to fetch stage (registered).
- wud__mcntl__valid  out  1  record available.
- mcntl__wud__ready  in  1  consumer accepts record.
- wud__mcntl__opcode  out  4  instruction opcode.
- wud__mcntl__tag  out  22  instruction tag.
- wud__mcntl__num_opts  out  4  valid option count.
- wud__mcntl__opt_id  out  4*MAX_OPTS  option ids, slot 0 in LSBs.
- wud__mcntl__opt_val  out  16*MAX_OPTS  option values, slot 0 in LSBs.
- wud__mcntl__err  out  1  sticky decode/overflow error.

Behaviour:
- Reset: all outputs 0. FIFO empty. FSM in WUD_IDLE. Reset asserted mid-instruction discards partial record and FIFO contents.
- Word type is data[31:30]:
  - 00: NOP. Ignored in every state.
  - 01: HEADER. [29:26] opcode, [25:22] num_opts, [21:0] tag.
  - 10: OPTION. [29:26] id, [15:0] value.
  - 11: END.
- FSM states and transitions (only on cycles with wum__wud__valid=1):
  - WUD_IDLE: HEADER with num_opts<=MAX_OPTS captures opcode/tag/num_opts and clears the option slots. It then goes to WUD_OPTS if num_opts>0, else WUD_WAIT_END. OPTION or END goes to WUD_ERR. HEADER with num_opts>MAX_OPTS goes to WUD_ERR.
  - WUD_OPTS: OPTION stores into slot opt_cnt, and opt_cnt increments. When opt_cnt reaches num_opts-1, go to WUD_WAIT_END. HEADER or END goes to WUD_ERR.
  - WUD_WAIT_END: END pushes the assembled record into the FIFO on the same edge and returns to WUD_IDLE. HEADER or OPTION goes to WUD_ERR.
  - WUD_ERR: latched until reset. wud__mcntl__err=1. Further words dropped. The FIFO keeps draining.
- Unused option slots read 0.
- Overflow: an END push while the FIFO is full drops the record, sets err, and goes to WUD_ERR.
- Latency: END accepted at edge N gives wud__mcntl__valid=1 after edge N (first-word fall-through output). A record is consumed on a cycle with valid&ready=1.
- Push and pop in the same cycle when full: pop takes effect first and the push succeeds (no overflow). Count is unchanged.
- Stall: wud__wud__stall next = (count_next >= FIFO_DEPTH-STALL_MARGIN), registered. It deasserts the cycle after count drops below the threshold.
- Count arithmetic uses log2(FIFO_DEPTH)+1 bits. Read/write pointers wrap modulo FIFO_DEPTH.

Optional Feature:
- Macro: WUD_PARITY_CHECK_EN.
- When defined, data[WU_WORD_W-1:0] is extended by input wum__wud__parity (1 bit, even parity over the word). A valid word with a parity mismatch moves the FSM to WUD_ERR and sets err.
- When undefined, the parity port is absent and no check is performed.

Decomposition:
- wu_decode.vh holds: word-type encodings; field bit ranges; WUD_STATE_RANGE and state encodings (WUD_IDLE, WUD_OPTS, WUD_WAIT_END, WUD_ERR); record width macro.
- Sub-module wud_fifo: generic FWFT FIFO with count output, parameterised by width and depth. It is instantiated once with the packed record.

Test Plan:
1. Basic record:
   - Stimulus: HEADER(op=3, n=2, tag=0x1234), OPTION(id=1, val=0xAAAA), OPTION(id=7, val=0x0055), END with ready=1.
   - Response: valid 1 cycle after END. opcode=3, tag=0x1234, num_opts=2, opt_id=0x0071, opt_val slot0=0xAAAA, slot1=0x0055, slots 2-3 = 0. err=0.
2. Zero-option instruction with interleaved NOPs:
   - Stimulus: HEADER(op=5, n=0), NOP, NOP, END.
   - Response: one record, num_opts=0, all slots 0.
3. Stall threshold and overflow:
   - Stimulus: hold ready=0 with FIFO_DEPTH=8 and STALL_MARGIN=4. Push records.
   - Response: stall rises the cycle after the 4th push. A 9th END while full sets err and leaves count=8.
4. Protocol errors:
   - Stimulus: OPTION in IDLE, and separately HEADER with n=9.
   - Response: err=1 from the next cycle. Later valid words produce no records. Queued records still drain.
5. Full push+pop:
   - Stimulus: FIFO full, ready=1, END on the same cycle.
   - Response: no err, count stays 8, and record order is preserved.
6. Asynchronous reset mid-instruction:
   - Stimulus: drop reset_poweron_n between edges after HEADER+OPTION.
   - Response: outputs 0 immediately. A subsequent clean instruction decodes correctly.
   - With WUD_PARITY_CHECK_EN defined, a single-bit parity flip sets err.
